// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one CORDIC core between NREQ requesters.
// One op is in flight at a time; each result comes back tagged with the requester id.
module cordic_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                    clka,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_mode,
    input  logic [NREQ*DW-1:0]      req_x,
    input  logic [NREQ*DW-1:0]      req_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_x,
    output logic [DW-1:0]           rsp_y,
    output logic                    rsp_err,
    output logic                    core_start,
    output logic                    core_mode,
    output logic [DW-1:0]           core_in0,
    output logic [DW-1:0]           core_in1,
    input  logic [DW-1:0]           core_out0,
    input  logic [DW-1:0]           core_out1,
    input  logic                    core_done,
    output logic                    busy
);
    localparam int ID_W = $clog2(NREQ);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [TW-1:0]   r_timer;
    logic            r_core_start;
    logic            r_core_mode;
    logic [DW-1:0]   r_core_in0;
    logic [DW-1:0]   r_core_in1;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_x;
    logic [DW-1:0]   r_rsp_y;
    logic            r_rsp_err;

    logic            w_any;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [DW-1:0]   w_gnt_x;
    logic [DW-1:0]   w_gnt_y;
    logic            w_tmo;
    logic [TW-1:0]   w_timer_inc;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_ptr_nxt   = ID_W'((int'(w_gnt_idx) + 1) % NREQ);
    assign w_gnt_x     = req_x[int'(w_gnt_idx)*DW +: DW];
    assign w_gnt_y     = req_y[int'(w_gnt_idx)*DW +: DW];
    assign w_tmo       = (r_timer == TW'(TIMEOUT));
    assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + TW'(1);

    // The accept pulse is combinational so the grant and the operand sampling share one edge.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_timer      <= '0;
            r_core_start <= 1'b0;
            r_core_mode  <= 1'b0;
            r_core_in0   <= '0;
            r_core_in1   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_core_mode  <= req_mode[w_gnt_idx];
                        r_core_in0   <= w_gnt_x;
                        r_core_in1   <= w_gnt_y;
                        r_id         <= w_gnt_idx;
                        r_ptr        <= w_ptr_nxt;
                        r_core_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_LO;
                end
                // A done level still high from the previous op must drop before we trust it.
                S_WAIT_LO: begin
                    if (!core_done) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_HI;
                    end else if (w_tmo) begin
                        r_rsp_x     <= '0;
                        r_rsp_y     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_WAIT_HI: begin
                    if (core_done) begin
                        r_rsp_x     <= core_out0;
                        r_rsp_y     <= core_out1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_rsp_x     <= '0;
                        r_rsp_y     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_id;
    assign rsp_x      = r_rsp_x;
    assign rsp_y      = r_rsp_y;
    assign rsp_err    = r_rsp_err;
    assign core_start = r_core_start;
    assign core_mode  = r_core_mode;
    assign core_in0   = r_core_in0;
    assign core_in1   = r_core_in1;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: a toy core plus a transaction-level model of
// round-robin grants, response timing and response contents.
module tb_cordic_rr_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 63;
    localparam int IDW  = 2;

    logic                 clka = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_mode;
    logic [NREQ*DW-1:0]   req_x;
    logic [NREQ*DW-1:0]   req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_x;
    logic [DW-1:0]        rsp_y;
    logic                 rsp_err;
    logic                 core_start;
    logic                 core_mode;
    logic [DW-1:0]        core_in0;
    logic [DW-1:0]        core_in1;
    logic [DW-1:0]        core_out0 = '0;
    logic [DW-1:0]        core_out1 = '0;
    logic                 core_done;
    logic                 busy;

    always #5 clka = ~clka;

    cordic_rr_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
        .clka(clka), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .core_start(core_start), .core_mode(core_mode),
        .core_in0(core_in0), .core_in1(core_in1),
        .core_out0(core_out0), .core_out1(core_out1), .core_done(core_done),
        .busy(busy)
    );

    function automatic logic [DW-1:0] f0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        return a + b + DW'(m);
    endfunction

    function automatic logic [DW-1:0] f1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        return a ^ b ^ {DW{m}};
    endfunction

    // Toy core: done drops after start, rises cfg_lat cycles later; outputs are junk until then.
    int            cfg_lat   = 16;
    int            cfg_stuck = 0;
    int            cm_cnt    = 0;
    logic          cm_done   = 1'b0;
    logic [DW-1:0] cm_a      = '0;
    logic [DW-1:0] cm_b      = '0;
    logic          cm_m      = 1'b0;

    always @(posedge clka) begin
        if (core_start) begin
            cm_done   <= 1'b0;
            cm_cnt    <= cfg_lat;
            cm_a      <= core_in0;
            cm_b      <= core_in1;
            cm_m      <= core_mode;
            core_out0 <= DW'($urandom);
            core_out1 <= DW'($urandom);
        end else if (cm_cnt > 0) begin
            cm_cnt <= cm_cnt - 1;
            if (cm_cnt == 1) begin
                cm_done   <= 1'b1;
                core_out0 <= f0(cm_a, cm_b, cm_m);
                core_out1 <= f1(cm_a, cm_b, cm_m);
            end else begin
                core_out0 <= DW'($urandom);
                core_out1 <= DW'($urandom);
            end
        end
    end

    assign core_done = (cfg_stuck == 1) ? 1'b1 : (cfg_stuck == 2) ? 1'b0 : cm_done;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester-side and reference-model state.
    logic [NREQ-1:0] pend;
    logic [DW-1:0]   dx [NREQ];
    logic [DW-1:0]   dy [NREQ];
    logic            dm [NREQ];
    bit              refill;
    int              hold_min, hold_max, hold;
    int              mptr;
    bit              outst;
    int              t_gnt, r_due, cyc;
    int              e_id;
    logic [DW-1:0]   e_x, e_y, e_in0, e_in1;
    logic            e_err, e_mode;

    task automatic new_req(input int i);
        dx[i]   = DW'($urandom);
        dy[i]   = DW'($urandom);
        dm[i]   = 1'($urandom);
        pend[i] = 1'b1;
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_mode[i]          = dm[i];
            req_x[i*DW +: DW]    = dx[i];
            req_y[i*DW +: DW]    = dy[i];
        end
        rsp_ready = outst && (cyc >= r_due + hold);
    endtask

    task automatic run(input int want, input int budget, input bit must);
        int got = 0;
        for (int k = 0; k < budget && got < want; k++) begin
            int g;
            bit hs;
            logic [NREQ-1:0] exp_rdy;
            drive();
            @(negedge clka);
            g = -1;
            exp_rdy = '0;
            if (!outst) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (g < 0 && pend[(mptr + j) % NREQ]) g = (mptr + j) % NREQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(outst));
            chk("core_start", 32'(core_start), 32'(outst && cyc == t_gnt + 1));
            chk("rsp_valid", 32'(rsp_valid), 32'(outst && cyc >= r_due));
            if (outst) begin
                chk("core_mode", 32'(core_mode), 32'(e_mode));
                chk("core_in0", 32'(core_in0), 32'(e_in0));
                chk("core_in1", 32'(core_in1), 32'(e_in1));
            end
            if (outst && cyc >= r_due) begin
                chk("rsp_id", 32'(rsp_id), 32'(e_id));
                chk("rsp_x", 32'(rsp_x), 32'(e_x));
                chk("rsp_y", 32'(rsp_y), 32'(e_y));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end
            hs = outst && (cyc >= r_due) && rsp_ready;
            @(posedge clka);
            #1;
            cyc++;
            if (hs) begin
                outst = 0;
                got++;
            end
            if (g >= 0) begin
                outst  = 1;
                t_gnt  = cyc - 1;
                e_id   = g;
                e_mode = dm[g];
                e_in0  = dx[g];
                e_in1  = dy[g];
                e_err  = (cfg_stuck != 0);
                e_x    = e_err ? '0 : f0(dx[g], dy[g], dm[g]);
                e_y    = e_err ? '0 : f1(dx[g], dy[g], dm[g]);
                r_due  = (cfg_stuck == 1) ? t_gnt + 3 + TO :
                         (cfg_stuck == 2) ? t_gnt + 4 + TO : t_gnt + 3 + cfg_lat;
                hold   = int'($urandom_range(hold_max, hold_min));
                mptr   = (g + 1) % NREQ;
                pend[g] = 1'b0;
                if (refill) new_req(g);
            end
        end
        if (must) chk("budget", 32'(got >= want), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        pend = '0; refill = 0; hold_min = 0; hold_max = 0; hold = 0;
        outst = 0; mptr = 0; t_gnt = -100; r_due = 0; cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            dx[i] = '0; dy[i] = '0; dm[i] = 1'b0;
        end
        drive();
        repeat (3) @(posedge clka);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_x", 32'(rsp_x), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_core_in0", 32'(core_in0), 32'd0);
        chk("rst_core_mode", 32'(core_mode), 32'd0);
        reset = 1'b1;

        // Single request from port 0 with a 16-cycle core.
        cfg_lat = 16;
        dx[0] = 8'h40; dy[0] = 8'h00; dm[0] = 1'b1; pend = 4'b0001;
        run(1, 60, 1);

        // Reset in the middle of WAIT_HI abandons the op immediately.
        new_req(0);
        run(1, 6, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_core_start", 32'(core_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        pend = '0;
        drive();
        @(posedge clka);
        #1;
        cyc++;
        reset = 1'b1;
        outst = 0; mptr = 0; t_gnt = -100;

        // All four held valid at minimum core latency: order 0,1,2,3,0.
        cfg_lat = 1; refill = 1;
        for (int i = 0; i < NREQ; i++) new_req(i);
        run(5, 60, 1);
        refill = 0;

        // Move the pointer to 2, then offer only ports 0 and 1.
        pend = 4'b0010;
        run(1, 20, 1);
        new_req(0); new_req(1);
        run(2, 30, 1);

        // Consumer stalls 10 cycles while another request waits.
        hold_min = 10; hold_max = 10; cfg_lat = 3;
        new_req(0); new_req(2);
        run(2, 60, 1);
        hold_min = 0; hold_max = 0;

        // Timeouts: done stuck high, then stuck low.
        cfg_stuck = 1;
        new_req(3);
        run(1, 100, 1);
        cfg_stuck = 2;
        new_req(1);
        run(1, 100, 1);
        cfg_stuck = 0;

        // Random arrivals, latencies and consumer stalls.
        hold_max = 3;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) new_req(i);
            end
            if (pend == '0) new_req(int'($urandom_range(NREQ - 1, 0)));
            cfg_lat = int'($urandom_range(6, 1));
            run(1, 60, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
